// File: rtl/turn_controller_if.sv
// Bomb-side link of the turn controller: launch request, aim/power and the
// bomb's exploded flag coming back.
interface turn_controller_if;
   logic       launch;
   logic [9:0] launch_x;
   logic [9:0] launch_y;
   logic [3:0] angle;
   logic [2:0] power;
   logic       exploded;

   modport master (
      output launch, launch_x, launch_y, angle, power,
      input  exploded
   );

   modport slave (
      input  launch, launch_x, launch_y, angle, power,
      output exploded
   );
endinterface

// File: rtl/turn_controller.sv
// Sequences one artillery turn per player: aim, charge, launch, flight,
// settle, then hand over to the other player. One step per video frame.
//
// state  | meaning
// AIM    | angle buttons adjust the active player's angle, fire press starts charging
// CHARGE | power ramps one step every CHARGE_FRAMES while fire is held
// LAUNCH | one-frame launch strobe, launch position latched on entry
// FLIGHT | waiting for the bomb to explode or for the flight timeout
// SETTLE | fixed hold while terrain is rewritten, then next player
module turn_controller #(
   parameter int CHARGE_FRAMES  = 8,
   parameter int FLIGHT_TIMEOUT = 255,
   parameter int SETTLE_FRAMES  = 30,
   parameter int ANGLE_DEFAULT  = 4
) (
   input  logic                      frame_clk,
   input  logic                      reset,
   input  logic                      i_btn_fire,
   input  logic                      i_btn_left,
   input  logic                      i_btn_right,
   input  logic [9:0]                i_tank0_x,
   input  logic [9:0]                i_tank0_y,
   input  logic [9:0]                i_tank1_x,
   input  logic [9:0]                i_tank1_y,
   turn_controller_if.master         bomb,
   output logic                      o_player,
   output logic [2:0]                o_state,
   output logic                      o_timed_out,
   output logic [7:0]                o_turn_cnt
);

   typedef enum logic [2:0] {
      AIM    = 3'd0,
      CHARGE = 3'd1,
      LAUNCH = 3'd2,
      FLIGHT = 3'd3,
      SETTLE = 3'd4
   } state_t;

   localparam logic [3:0] ANGLE_RST = 4'(ANGLE_DEFAULT);
   localparam logic [3:0] ANGLE_MAX = 4'd8;
   localparam logic [7:0] CHARGE_TC = 8'(CHARGE_FRAMES - 1);
   localparam logic [7:0] FLIGHT_TC = 8'(FLIGHT_TIMEOUT);
   localparam logic [7:0] SETTLE_LD = 8'(SETTLE_FRAMES - 1);

   state_t     r_state, w_state;
   logic       r_player, w_player;
   logic [3:0] r_angle0, w_angle0;
   logic [3:0] r_angle1, w_angle1;
   logic [2:0] r_power, w_power;
   logic [7:0] r_charge_cnt, w_charge_cnt;
   logic [7:0] r_flight_cnt, w_flight_cnt;
   logic [7:0] r_settle_cnt, w_settle_cnt;
   logic       r_launch, w_launch;
   logic [9:0] r_launch_x, w_launch_x;
   logic [9:0] r_launch_y, w_launch_y;
   logic       r_timed_out, w_timed_out;
   logic [7:0] r_turn_cnt, w_turn_cnt;
   logic       r_fire_q, r_left_q, r_right_q;

   logic       w_fire_edge, w_left_edge, w_right_edge;
   logic [3:0] w_cur_angle, w_new_angle;
   logic [7:0] w_flight_inc;

   assign w_fire_edge  = i_btn_fire  & ~r_fire_q;
   assign w_left_edge  = i_btn_left  & ~r_left_q;
   assign w_right_edge = i_btn_right & ~r_right_q;
   assign w_cur_angle  = r_player ? r_angle1 : r_angle0;
   assign w_flight_inc = r_flight_cnt + 8'd1;

   // Angle step for AIM: a simultaneous left+right press cancels out.
   always_comb begin
      w_new_angle = w_cur_angle;
      if (w_left_edge && !w_right_edge && w_cur_angle != 4'd0)
         w_new_angle = w_cur_angle - 4'd1;
      else if (w_right_edge && !w_left_edge && w_cur_angle < ANGLE_MAX)
         w_new_angle = w_cur_angle + 4'd1;
   end

   // Next-state and next-register values; launch defaults low so it only
   // pulses for the single frame spent in LAUNCH.
   always_comb begin
      w_state      = r_state;
      w_player     = r_player;
      w_angle0     = r_angle0;
      w_angle1     = r_angle1;
      w_power      = r_power;
      w_charge_cnt = r_charge_cnt;
      w_flight_cnt = r_flight_cnt;
      w_settle_cnt = r_settle_cnt;
      w_launch     = 1'b0;
      w_launch_x   = r_launch_x;
      w_launch_y   = r_launch_y;
      w_timed_out  = r_timed_out;
      w_turn_cnt   = r_turn_cnt;
      case (r_state)
         AIM: begin
            if (r_player) w_angle1 = w_new_angle;
            else          w_angle0 = w_new_angle;
            if (w_fire_edge) begin
               w_state      = CHARGE;
               w_power      = 3'd0;
               w_charge_cnt = 8'd0;
            end
         end
         CHARGE: begin
            if (!i_btn_fire) begin
               w_state    = LAUNCH;
               w_launch   = 1'b1;
               w_launch_x = r_player ? i_tank1_x : i_tank0_x;
               w_launch_y = r_player ? i_tank1_y : i_tank0_y;
            end else if (r_charge_cnt == CHARGE_TC) begin
               w_charge_cnt = 8'd0;
               if (r_power != 3'd7) w_power = r_power + 3'd1;
            end else begin
               w_charge_cnt = r_charge_cnt + 8'd1;
            end
         end
         LAUNCH: begin
            w_state      = FLIGHT;
            w_flight_cnt = 8'd0;
            w_timed_out  = 1'b0;
         end
         FLIGHT: begin
            w_flight_cnt = w_flight_inc;
            // First flight frame ignores the bomb's stale exploded flag.
            if (r_flight_cnt != 8'd0 && bomb.exploded) begin
               w_state      = SETTLE;
               w_settle_cnt = SETTLE_LD;
            end else if (w_flight_inc == FLIGHT_TC) begin
               w_state      = SETTLE;
               w_settle_cnt = SETTLE_LD;
               w_timed_out  = 1'b1;
            end
         end
         SETTLE: begin
            if (r_settle_cnt == 8'd0) begin
               w_state    = AIM;
               w_player   = ~r_player;
               w_power    = 3'd0;
               w_turn_cnt = r_turn_cnt + 8'd1;
            end else begin
               w_settle_cnt = r_settle_cnt - 8'd1;
            end
         end
         default: w_state = AIM;
      endcase
   end

   // State and datapath registers, plus previous-frame button levels.
   always_ff @(posedge frame_clk or posedge reset) begin
      if (reset) begin
         r_state      <= AIM;
         r_player     <= 1'b0;
         r_angle0     <= ANGLE_RST;
         r_angle1     <= ANGLE_RST;
         r_power      <= 3'd0;
         r_charge_cnt <= 8'd0;
         r_flight_cnt <= 8'd0;
         r_settle_cnt <= 8'd0;
         r_launch     <= 1'b0;
         r_launch_x   <= 10'd0;
         r_launch_y   <= 10'd0;
         r_timed_out  <= 1'b0;
         r_turn_cnt   <= 8'd0;
         r_fire_q     <= 1'b0;
         r_left_q     <= 1'b0;
         r_right_q    <= 1'b0;
      end else begin
         r_state      <= w_state;
         r_player     <= w_player;
         r_angle0     <= w_angle0;
         r_angle1     <= w_angle1;
         r_power      <= w_power;
         r_charge_cnt <= w_charge_cnt;
         r_flight_cnt <= w_flight_cnt;
         r_settle_cnt <= w_settle_cnt;
         r_launch     <= w_launch;
         r_launch_x   <= w_launch_x;
         r_launch_y   <= w_launch_y;
         r_timed_out  <= w_timed_out;
         r_turn_cnt   <= w_turn_cnt;
         r_fire_q     <= i_btn_fire;
         r_left_q     <= i_btn_left;
         r_right_q    <= i_btn_right;
      end
   end

   assign bomb.launch   = r_launch;
   assign bomb.launch_x = r_launch_x;
   assign bomb.launch_y = r_launch_y;
   assign bomb.angle    = w_cur_angle;
   assign bomb.power    = r_power;
   assign o_player      = r_player;
   assign o_state       = r_state;
   assign o_timed_out   = r_timed_out;
   assign o_turn_cnt    = r_turn_cnt;

endmodule

// File: tb/tb_turn_controller.sv
// Directed bench for turn_controller: reset, aiming, charging, launch,
// flight/explosion, timeout, mid-flight reset and turn counter wrap.
module tb_turn_controller;

   logic       frame_clk = 1'b0;
   logic       reset;
   logic       btn_fire, btn_left, btn_right;
   logic [9:0] tank0_x, tank0_y, tank1_x, tank1_y;
   logic       player, timed_out;
   logic [2:0] state;
   logic [7:0] turn_cnt;

   int n_checks = 0;
   int n_errors = 0;

   turn_controller_if bus ();

   turn_controller dut (
      .frame_clk   (frame_clk),
      .reset       (reset),
      .i_btn_fire  (btn_fire),
      .i_btn_left  (btn_left),
      .i_btn_right (btn_right),
      .i_tank0_x   (tank0_x),
      .i_tank0_y   (tank0_y),
      .i_tank1_x   (tank1_x),
      .i_tank1_y   (tank1_y),
      .bomb        (bus.master),
      .o_player    (player),
      .o_state     (state),
      .o_timed_out (timed_out),
      .o_turn_cnt  (turn_cnt)
   );

   always #5 frame_clk = ~frame_clk;

   task automatic tick();
      @(posedge frame_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Minimal turn: press/release fire, explode in the 2nd flight frame, settle.
   task automatic quick_turn();
      btn_fire = 1'b1; tick();
      btn_fire = 1'b0; tick();
      tick();
      tick();
      bus.exploded = 1'b1; tick();
      bus.exploded = 1'b0;
      repeat (30) tick();
   endtask

   initial begin
      reset = 1'b1;
      btn_fire = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
      bus.exploded = 1'b0;
      tank0_x = 10'd100; tank0_y = 10'd300;
      tank1_x = 10'd500; tank1_y = 10'd200;
      #12 reset = 1'b0;
      tick();

      // 1: reset values
      chk("rst_state",  32'(state), 0);
      chk("rst_player", 32'(player), 0);
      chk("rst_angle",  32'(bus.angle), 4);
      chk("rst_power",  32'(bus.power), 0);
      chk("rst_launch", 32'(bus.launch), 0);
      chk("rst_turn",   32'(turn_cnt), 0);
      chk("rst_tout",   32'(timed_out), 0);
      chk("rst_lx",     32'(bus.launch_x), 0);

      // 2: angle control
      btn_right = 1'b1; tick(); btn_right = 1'b0; tick();
      chk("angle_r1", 32'(bus.angle), 5);
      repeat (4) begin btn_right = 1'b1; tick(); btn_right = 1'b0; tick(); end
      chk("angle_sat8", 32'(bus.angle), 8);
      repeat (10) begin btn_left = 1'b1; tick(); btn_left = 1'b0; tick(); end
      chk("angle_sat0", 32'(bus.angle), 0);
      btn_right = 1'b1; tick(); btn_right = 1'b0; tick();
      chk("angle_r_from0", 32'(bus.angle), 1);
      btn_left = 1'b1; btn_right = 1'b1; tick();
      btn_left = 1'b0; btn_right = 1'b0; tick();
      chk("angle_both", 32'(bus.angle), 1);
      btn_right = 1'b1; repeat (20) tick();
      chk("angle_held", 32'(bus.angle), 2);
      btn_right = 1'b0; tick();

      // 3: charge
      btn_fire = 1'b1; tick();
      chk("charge_state", 32'(state), 1);
      chk("charge_p0", 32'(bus.power), 0);
      repeat (24) tick();
      chk("charge_p3", 32'(bus.power), 3);
      repeat (30) tick();
      btn_left = 1'b1; tick(); btn_left = 1'b0;
      repeat (45) tick();
      chk("charge_p7", 32'(bus.power), 7);
      chk("charge_angle_ign", 32'(bus.angle), 2);
      chk("charge_still", 32'(state), 1);

      // release -> LAUNCH; stale exploded high through LAUNCH and 1st FLIGHT frame
      btn_fire = 1'b0; bus.exploded = 1'b1; tick();
      chk("launch_state", 32'(state), 2);
      chk("launch_hi", 32'(bus.launch), 1);
      chk("launch_x0", 32'(bus.launch_x), 100);
      chk("launch_y0", 32'(bus.launch_y), 300);
      chk("launch_pwr", 32'(bus.power), 7);
      tick();
      chk("flight_state", 32'(state), 3);
      chk("launch_lo", 32'(bus.launch), 0);
      tick();
      chk("stale_ignored", 32'(state), 3);
      bus.exploded = 1'b0;
      repeat (9) tick();
      chk("flight_wait", 32'(state), 3);

      // 4: explosion -> SETTLE -> handover
      bus.exploded = 1'b1; tick();
      bus.exploded = 1'b0;
      chk("settle_state", 32'(state), 4);
      chk("settle_tout", 32'(timed_out), 0);
      repeat (29) tick();
      chk("settle_hold", 32'(state), 4);
      chk("settle_player", 32'(player), 0);
      btn_fire = 1'b1; tick();
      chk("handover_state", 32'(state), 0);
      chk("handover_player", 32'(player), 1);
      chk("handover_turn", 32'(turn_cnt), 1);
      chk("handover_angle", 32'(bus.angle), 4);
      chk("handover_power", 32'(bus.power), 0);
      tick();
      chk("fire_in_settle_ign", 32'(state), 0);
      btn_fire = 1'b0; tick();

      // 5: timeout (player 1)
      btn_fire = 1'b1; tick();
      btn_fire = 1'b0; tick();
      chk("p1_launch", 32'(bus.launch), 1);
      chk("p1_lx", 32'(bus.launch_x), 500);
      chk("p1_ly", 32'(bus.launch_y), 200);
      tick();
      repeat (254) tick();
      chk("tout_frame255", 32'(state), 3);
      tick();
      chk("tout_settle", 32'(state), 4);
      chk("tout_flag", 32'(timed_out), 1);
      repeat (30) tick();
      chk("tout_aim", 32'(state), 0);
      chk("tout_player", 32'(player), 0);
      chk("tout_turn", 32'(turn_cnt), 2);
      chk("tout_flag_kept", 32'(timed_out), 1);

      // explosion in frame 255 wins over timeout (player 0)
      btn_fire = 1'b1; tick();
      btn_fire = 1'b0; tick();
      tick();
      chk("tout_cleared", 32'(timed_out), 0);
      repeat (254) tick();
      bus.exploded = 1'b1; tick();
      bus.exploded = 1'b0;
      chk("tie_settle", 32'(state), 4);
      chk("tie_flag", 32'(timed_out), 0);
      repeat (30) tick();
      chk("tie_turn", 32'(turn_cnt), 3);

      // 6: asynchronous reset during FLIGHT (player 1)
      btn_fire = 1'b1; tick();
      btn_fire = 1'b0; tick();
      bus.exploded = 1'b0;
      tick(); tick(); tick();
      chk("pre_rst_flight", 32'(state), 3);
      #2 reset = 1'b1;
      #1;
      chk("arst_state", 32'(state), 0);
      chk("arst_launch", 32'(bus.launch), 0);
      chk("arst_player", 32'(player), 0);
      chk("arst_turn", 32'(turn_cnt), 0);
      #1 reset = 1'b0;
      tick();

      // turn counter wrap
      repeat (255) quick_turn();
      chk("turn_255", 32'(turn_cnt), 255);
      quick_turn();
      chk("turn_wrap", 32'(turn_cnt), 0);
      chk("wrap_state", 32'(state), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
